// File: rtl/ndn_pkg.sv
// Shared NDN forwarding-plane constants and the PIT controller state encoding.
package ndn_pkg;

    localparam int PREFIX_W   = 64;
    localparam int LEN_W      = 6;
    localparam int PIT_DEPTH  = 16;
    localparam int IDX_W      = $clog2(PIT_DEPTH);
    localparam int DATA_BYTES = 1024;
    localparam int CNT_W      = 11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_ALLOC  = 3'd2,
        S_FWD    = 3'd3,
        S_GRANT  = 3'd4,
        S_STREAM = 3'd5,
        S_REJECT = 3'd6
    } pit_state_e;

endpackage

// File: rtl/pit_entry_store.sv
// PIT entry register file: one combinational read port, one set port, one clear port.
module pit_entry_store
    import ndn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic [LEN_W-1:0]     rd_len,
    output logic [PREFIX_W-1:0]  rd_prefix,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [LEN_W-1:0]     wr_len,
    input  logic [PREFIX_W-1:0]  wr_prefix,
    input  logic                 clr_en,
    input  logic [IDX_W-1:0]     clr_idx,
    output logic [PIT_DEPTH-1:0] valid_mask
);

    logic [PIT_DEPTH-1:0] valid_q;
    logic [LEN_W-1:0]     len_q    [PIT_DEPTH];
    logic [PREFIX_W-1:0]  prefix_q [PIT_DEPTH];

    // Only the valid bits need reset; key fields are ignored while invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            if (wr_en)  valid_q[wr_idx]  <= 1'b1;
            if (clr_en) valid_q[clr_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            len_q[wr_idx]    <= wr_len;
            prefix_q[wr_idx] <= wr_prefix;
        end
    end

    assign rd_valid   = valid_q[rd_idx];
    assign rd_len     = len_q[rd_idx];
    assign rd_prefix  = prefix_q[rd_idx];
    assign valid_mask = valid_q;

endmodule

// File: rtl/pit_table.sv
// Pending Interest Table controller: sequential 16-entry search, interest
// aggregation/forwarding, and data grant with a 1024-byte stream pass-through.
module pit_table
    import ndn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 interest_valid,
    input  logic [PREFIX_W-1:0]  interest_prefix,
    input  logic [LEN_W-1:0]     interest_len,
    output logic                 interest_ready,
    output logic                 fib_out_bit,
    output logic [PREFIX_W-1:0]  fib_prefix,
    output logic [LEN_W-1:0]     fib_len,
    input  logic                 prefix_ready,
    input  logic [PREFIX_W-1:0]  data_prefix,
    input  logic [LEN_W-1:0]     data_len,
    output logic                 start_send_to_pit,
    output logic                 rejected,
    input  logic [7:0]           fib_data,
    output logic [7:0]           pkt_out_data,
    output logic                 pkt_out_valid,
    output logic                 interest_dropped,
    output pit_state_e           state_dbg,
    output logic [PIT_DEPTH-1:0] valid_dbg
);

    pit_state_e           state;
    logic [PREFIX_W-1:0]  key_prefix;
    logic [LEN_W-1:0]     key_len;
    logic                 key_is_data;
    logic [IDX_W-1:0]     idx;
    logic                 match_found;
    logic [IDX_W-1:0]     match_idx;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic                 pend_valid;
    logic [PREFIX_W-1:0]  pend_prefix;
    logic [LEN_W-1:0]     pend_len;
    logic [CNT_W-1:0]     byte_cnt;

    logic                 rd_valid;
    logic [LEN_W-1:0]     rd_len;
    logic [PREFIX_W-1:0]  rd_prefix;
    logic                 cur_match;
    logic                 hit;
    logic [IDX_W-1:0]     hit_idx;
    logic                 has_free;
    logic [IDX_W-1:0]     free_sel;

    pit_entry_store u_store (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (idx),
        .rd_valid   (rd_valid),
        .rd_len     (rd_len),
        .rd_prefix  (rd_prefix),
        .wr_en      (state == S_ALLOC),
        .wr_idx     (free_idx),
        .wr_len     (key_len),
        .wr_prefix  (key_prefix),
        .clr_en     (state == S_GRANT),
        .clr_idx    (match_idx),
        .valid_mask (valid_dbg)
    );

    // Final-cycle decision folds in the entry being compared right now.
    assign cur_match = rd_valid && (rd_len == key_len) && (rd_prefix == key_prefix);
    assign hit       = match_found || cur_match;
    assign hit_idx   = match_found ? match_idx : idx;
    assign has_free  = free_found || !rd_valid;
    assign free_sel  = free_found ? free_idx : idx;

    // Interest handshake: a beat transfers on a rising edge where both
    // interest_valid and interest_ready are 1; ready drops whenever a data
    // request (live or pending) is waiting, so data always wins the IDLE slot.
    assign interest_ready = rst && (state == S_IDLE) && !pend_valid && !prefix_ready;
    assign state_dbg      = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= S_IDLE;
            key_prefix        <= '0;
            key_len           <= '0;
            key_is_data       <= 1'b0;
            idx               <= '0;
            match_found       <= 1'b0;
            match_idx         <= '0;
            free_found        <= 1'b0;
            free_idx          <= '0;
            pend_valid        <= 1'b0;
            pend_prefix       <= '0;
            pend_len          <= '0;
            byte_cnt          <= '0;
            fib_out_bit       <= 1'b0;
            fib_prefix        <= '0;
            fib_len           <= '0;
            start_send_to_pit <= 1'b0;
            rejected          <= 1'b0;
            interest_dropped  <= 1'b0;
            pkt_out_valid     <= 1'b0;
            pkt_out_data      <= '0;
        end else begin
            fib_out_bit       <= 1'b0;
            fib_prefix        <= '0;
            fib_len           <= '0;
            start_send_to_pit <= 1'b0;
            rejected          <= 1'b0;
            interest_dropped  <= 1'b0;
            pkt_out_valid     <= 1'b0;
            pkt_out_data      <= '0;

            if (prefix_ready && (state != S_IDLE) && !pend_valid) begin
                pend_valid  <= 1'b1;
                pend_prefix <= data_prefix;
                pend_len    <= data_len;
            end

            case (state)
                S_IDLE: begin
                    idx         <= '0;
                    match_found <= 1'b0;
                    free_found  <= 1'b0;
                    if (pend_valid) begin
                        key_prefix  <= pend_prefix;
                        key_len     <= pend_len;
                        key_is_data <= 1'b1;
                        state       <= S_SEARCH;
                        // A fresh request arriving now refills the slot just drained.
                        pend_valid  <= prefix_ready;
                        if (prefix_ready) begin
                            pend_prefix <= data_prefix;
                            pend_len    <= data_len;
                        end
                    end else if (prefix_ready) begin
                        key_prefix  <= data_prefix;
                        key_len     <= data_len;
                        key_is_data <= 1'b1;
                        state       <= S_SEARCH;
                    end else if (interest_valid) begin
                        key_prefix  <= interest_prefix;
                        key_len     <= interest_len;
                        key_is_data <= 1'b0;
                        state       <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (cur_match && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (!rd_valid && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(PIT_DEPTH - 1)) begin
                        match_idx <= hit_idx;
                        free_idx  <= free_sel;
                        if (key_is_data) begin
                            if (hit) begin
                                state             <= S_GRANT;
                                start_send_to_pit <= 1'b1;
                            end else begin
                                state    <= S_REJECT;
                                rejected <= 1'b1;
                            end
                        end else if (hit) begin
                            state <= S_IDLE;
                        end else if (has_free) begin
                            state <= S_ALLOC;
                        end else begin
                            state            <= S_IDLE;
                            interest_dropped <= 1'b1;
                        end
                    end
                end
                S_ALLOC: begin
                    fib_out_bit <= 1'b1;
                    fib_prefix  <= key_prefix;
                    fib_len     <= key_len;
                    state       <= S_FWD;
                end
                S_FWD: begin
                    state <= S_IDLE;
                end
                S_GRANT: begin
                    byte_cnt <= '0;
                    state    <= S_STREAM;
                end
                S_STREAM: begin
                    pkt_out_valid <= 1'b1;
                    pkt_out_data  <= fib_data;
                    byte_cnt      <= byte_cnt + 1'b1;
                    if (byte_cnt == CNT_W'(DATA_BYTES - 1)) begin
                        state <= S_IDLE;
                    end
                end
                S_REJECT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pit_table.sv
// Directed testbench for pit_table: interest forwarding, aggregation, table-full
// drop, data grant/stream, pending data requests, entry reuse and mid-stream reset.
module tb_pit_table;
    import ndn_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 interest_valid = 1'b0;
    logic [PREFIX_W-1:0]  interest_prefix = '0;
    logic [LEN_W-1:0]     interest_len = '0;
    logic                 interest_ready;
    logic                 fib_out_bit;
    logic [PREFIX_W-1:0]  fib_prefix;
    logic [LEN_W-1:0]     fib_len;
    logic                 prefix_ready = 1'b0;
    logic [PREFIX_W-1:0]  data_prefix = '0;
    logic [LEN_W-1:0]     data_len = '0;
    logic                 start_send_to_pit;
    logic                 rejected;
    logic [7:0]           fib_data = '0;
    logic [7:0]           pkt_out_data;
    logic                 pkt_out_valid;
    logic                 interest_dropped;
    pit_state_e           state_dbg;
    logic [PIT_DEPTH-1:0] valid_dbg;

    int tests = 0;
    int fails = 0;

    localparam logic [63:0] PFX_A = 64'hA5A5_0000_0000_0001;
    localparam logic [63:0] PFX_B = 64'h0000_0000_0000_BEEF;
    localparam logic [63:0] PFX_F = 64'h1000_0000_0000_0000;

    pit_table dut (
        .clk               (clk),
        .rst               (rst),
        .interest_valid    (interest_valid),
        .interest_prefix   (interest_prefix),
        .interest_len      (interest_len),
        .interest_ready    (interest_ready),
        .fib_out_bit       (fib_out_bit),
        .fib_prefix        (fib_prefix),
        .fib_len           (fib_len),
        .prefix_ready      (prefix_ready),
        .data_prefix       (data_prefix),
        .data_len          (data_len),
        .start_send_to_pit (start_send_to_pit),
        .rejected          (rejected),
        .fib_data          (fib_data),
        .pkt_out_data      (pkt_out_data),
        .pkt_out_valid     (pkt_out_valid),
        .interest_dropped  (interest_dropped),
        .state_dbg         (state_dbg),
        .valid_dbg         (valid_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b0;
        interest_valid = 1'b0;
        prefix_ready = 1'b0;
        fib_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; the cycle holding interest_valid is cycle 1.
    task automatic drive_interest(input logic [63:0] p, input logic [5:0] l);
        for (int k = 0; k < 200 && !interest_ready; k++) @(negedge clk);
        interest_valid  = 1'b1;
        interest_prefix = p;
        interest_len    = l;
        @(negedge clk);
        interest_valid  = 1'b0;
    endtask

    task automatic pulse_prefix(input logic [63:0] p, input logic [5:0] l);
        prefix_ready = 1'b1;
        data_prefix  = p;
        data_len     = l;
        @(negedge clk);
        prefix_ready = 1'b0;
    endtask

    // Observes cycles 2..40 after a request; stops at the grant cycle.
    task automatic watch(output int fc, output int dc, output int rc, output int sc,
                         output int fn, output logic [63:0] fp, output logic [5:0] fl);
        fc = -1; dc = -1; rc = -1; sc = -1; fn = 0; fp = '0; fl = '0;
        for (int c = 2; c <= 40; c++) begin
            if (fib_out_bit) begin
                fn++;
                if (fc < 0) begin fc = c; fp = fib_prefix; fl = fib_len; end
            end
            if (interest_dropped && dc < 0) dc = c;
            if (rejected && rc < 0) rc = c;
            if (start_send_to_pit) begin sc = c; break; end
            @(negedge clk);
        end
    endtask

    // Feeds a byte ramp from the first STREAM cycle and counts correct outputs;
    // optionally injects data requests at given byte positions.
    task automatic run_stream(input int n, input int inj_a, input logic [63:0] pa,
                              input int inj_b, input logic [63:0] pb, output int good);
        good = 0;
        for (int i = 0; i < n; i++) begin
            fib_data = i[7:0];
            prefix_ready = 1'b0;
            if (i == inj_a) begin prefix_ready = 1'b1; data_prefix = pa; data_len = 6'd16; end
            if (i == inj_b) begin prefix_ready = 1'b1; data_prefix = pb; data_len = 6'd12; end
            @(negedge clk);
            if (pkt_out_valid === 1'b1 && pkt_out_data === i[7:0]) good++;
        end
        prefix_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        tests++; if (interest_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_low: got %b want 0", interest_ready); end
        tests++; if (pkt_out_valid !== 1'b0 || fib_out_bit !== 1'b0) begin fails++; $display("FAIL reset_outputs: pkt_out_valid=%b fib_out_bit=%b want 0", pkt_out_valid, fib_out_bit); end
        tests++; if (valid_dbg !== 16'h0000) begin fails++; $display("FAIL reset_table: got %h want 0000", valid_dbg); end
        tests++; if (state_dbg !== S_IDLE) begin fails++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_IDLE); end
        rst = 1'b1;
        #1;
        tests++; if (interest_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_release: got %b want 1", interest_ready); end
        @(negedge clk);
    endtask

    task automatic test_interest();
        int fc, dc, rc, sc, fn; logic [63:0] fp; logic [5:0] fl;
        drive_interest(PFX_A, 6'd16);
        watch(fc, dc, rc, sc, fn, fp, fl);
        tests++; if (fc != 19) begin fails++; $display("FAIL interest_latency: got cycle %0d want 19", fc); end
        tests++; if (fp !== PFX_A || fl !== 6'd16) begin fails++; $display("FAIL interest_fib_key: got %h/%0d want %h/16", fp, fl, PFX_A); end
        tests++; if (fn != 1 || dc != -1) begin fails++; $display("FAIL interest_pulses: fib=%0d drop_cycle=%0d want 1/-1", fn, dc); end
        tests++; if (valid_dbg !== 16'h0001) begin fails++; $display("FAIL interest_entry0: got %h want 0001", valid_dbg); end
    endtask

    task automatic test_aggregate();
        int fc, dc, rc, sc, fn; logic [63:0] fp; logic [5:0] fl;
        drive_interest(PFX_A, 6'd16);
        watch(fc, dc, rc, sc, fn, fp, fl);
        tests++; if (fn != 0 || dc != -1) begin fails++; $display("FAIL aggregate_pulses: fib=%0d drop_cycle=%0d want 0/-1", fn, dc); end
        tests++; if (valid_dbg !== 16'h0001) begin fails++; $display("FAIL aggregate_table: got %h want 0001", valid_dbg); end
    endtask

    task automatic test_data_grant();
        int fc, dc, rc, sc, fn, good; logic [63:0] fp; logic [5:0] fl;
        pulse_prefix(PFX_A, 6'd16);
        watch(fc, dc, rc, sc, fn, fp, fl);
        tests++; if (sc != 18 || rc != -1) begin fails++; $display("FAIL grant_latency: start_cycle=%0d rej_cycle=%0d want 18/-1", sc, rc); end
        @(negedge clk);
        run_stream(DATA_BYTES, -1, '0, -1, '0, good);
        tests++; if (good != 1024) begin fails++; $display("FAIL stream_bytes: got %0d want 1024", good); end
        @(negedge clk);
        tests++; if (pkt_out_valid !== 1'b0) begin fails++; $display("FAIL stream_end: pkt_out_valid=%b want 0", pkt_out_valid); end
        tests++; if (valid_dbg !== 16'h0000) begin fails++; $display("FAIL grant_clear: got %h want 0000", valid_dbg); end
        // Data and interest together: data wins, interest is not taken.
        prefix_ready = 1'b1; data_prefix = PFX_A; data_len = 6'd16;
        interest_valid = 1'b1; interest_prefix = PFX_B; interest_len = 6'd12;
        #1;
        tests++; if (interest_ready !== 1'b0) begin fails++; $display("FAIL collide_ready: got %b want 0", interest_ready); end
        @(negedge clk);
        prefix_ready = 1'b0; interest_valid = 1'b0;
        watch(fc, dc, rc, sc, fn, fp, fl);
        tests++; if (rc != 18 || sc != -1) begin fails++; $display("FAIL repeat_reject: rej_cycle=%0d start_cycle=%0d want 18/-1", rc, sc); end
        tests++; if (fn != 0 || valid_dbg !== 16'h0000) begin fails++; $display("FAIL collide_interest: fib=%0d table=%h want 0/0000", fn, valid_dbg); end
    endtask

    task automatic test_pending();
        int fc, dc, rc, sc, fn, good; logic [63:0] fp; logic [5:0] fl;
        drive_interest(PFX_A, 6'd16);
        watch(fc, dc, rc, sc, fn, fp, fl);
        drive_interest(PFX_B, 6'd12);
        watch(fc, dc, rc, sc, fn, fp, fl);
        tests++; if (valid_dbg !== 16'h0003) begin fails++; $display("FAIL pending_setup: got %h want 0003", valid_dbg); end
        pulse_prefix(PFX_A, 6'd16);
        watch(fc, dc, rc, sc, fn, fp, fl);
        @(negedge clk);
        // A (just cleared) goes pending; B arrives while pending is full and is lost.
        run_stream(DATA_BYTES, 100, PFX_A, 200, PFX_B, good);
        tests++; if (good != 1024) begin fails++; $display("FAIL pending_stream_bytes: got %0d want 1024", good); end
        @(negedge clk);
        watch(fc, dc, rc, sc, fn, fp, fl);
        tests++; if (rc != 18 || sc != -1) begin fails++; $display("FAIL pending_reject: rej_cycle=%0d start_cycle=%0d want 18/-1", rc, sc); end
        watch(fc, dc, rc, sc, fn, fp, fl);
        tests++; if (rc != -1 || sc != -1) begin fails++; $display("FAIL pending_lost: rej_cycle=%0d start_cycle=%0d want -1/-1", rc, sc); end
        tests++; if (valid_dbg !== 16'h0002) begin fails++; $display("FAIL pending_table: got %h want 0002", valid_dbg); end
    endtask

    task automatic test_table_full();
        int fc, dc, rc, sc, fn, total, on_time; logic [63:0] fp; logic [5:0] fl;
        do_reset();
        total = 0; on_time = 0;
        for (int k = 0; k < 16; k++) begin
            drive_interest(PFX_F + 64'(k), 6'd8);
            watch(fc, dc, rc, sc, fn, fp, fl);
            total += fn;
            if (fc == 19 && dc == -1) on_time++;
        end
        tests++; if (total != 16 || on_time != 16) begin fails++; $display("FAIL fill_fwd: pulses=%0d on_time=%0d want 16/16", total, on_time); end
        tests++; if (valid_dbg !== 16'hFFFF) begin fails++; $display("FAIL fill_table: got %h want ffff", valid_dbg); end
        drive_interest(PFX_F + 64'd16, 6'd8);
        watch(fc, dc, rc, sc, fn, fp, fl);
        tests++; if (dc != 18 || fn != 0) begin fails++; $display("FAIL full_drop: drop_cycle=%0d fib=%0d want 18/0", dc, fn); end
        tests++; if (valid_dbg !== 16'hFFFF) begin fails++; $display("FAIL full_table: got %h want ffff", valid_dbg); end
    endtask

    task automatic test_reuse();
        int fc, dc, rc, sc, fn, good; logic [63:0] fp; logic [5:0] fl;
        pulse_prefix(PFX_F + 64'd5, 6'd8);
        watch(fc, dc, rc, sc, fn, fp, fl);
        tests++; if (sc != 18) begin fails++; $display("FAIL reuse_grant: start_cycle=%0d want 18", sc); end
        @(negedge clk);
        run_stream(DATA_BYTES, -1, '0, -1, '0, good);
        @(negedge clk);
        tests++; if (good != 1024 || valid_dbg !== 16'hFFDF) begin fails++; $display("FAIL reuse_clear: bytes=%0d table=%h want 1024/ffdf", good, valid_dbg); end
        drive_interest(64'h2222, 6'd8);
        watch(fc, dc, rc, sc, fn, fp, fl);
        tests++; if (fc != 19 || fp !== 64'h2222 || dc != -1) begin fails++; $display("FAIL reuse_fwd: cycle=%0d prefix=%h drop=%0d want 19/2222/-1", fc, fp, dc); end
        tests++; if (valid_dbg !== 16'hFFFF) begin fails++; $display("FAIL reuse_table: got %h want ffff", valid_dbg); end
    endtask

    task automatic test_reset_mid_stream();
        int fc, dc, rc, sc, fn, good; logic [63:0] fp; logic [5:0] fl;
        pulse_prefix(PFX_F, 6'd8);
        watch(fc, dc, rc, sc, fn, fp, fl);
        @(negedge clk);
        run_stream(501, -1, '0, -1, '0, good);
        tests++; if (good != 501) begin fails++; $display("FAIL abort_bytes: got %0d want 501", good); end
        rst = 1'b0;
        #1;
        tests++; if (pkt_out_valid !== 1'b0) begin fails++; $display("FAIL abort_valid: got %b want 0", pkt_out_valid); end
        tests++; if (valid_dbg !== 16'h0000 || state_dbg !== S_IDLE) begin fails++; $display("FAIL abort_state: table=%h state=%0d want 0000/0", valid_dbg, state_dbg); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++; if (interest_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b want 1", interest_ready); end
        @(negedge clk);
        watch(fc, dc, rc, sc, fn, fp, fl);
        tests++; if (fn != 0 || rc != -1 || sc != -1 || dc != -1) begin fails++; $display("FAIL abort_quiet: fib=%0d rej=%0d start=%0d drop=%0d want 0/-1/-1/-1", fn, rc, sc, dc); end
        drive_interest(64'hC0DE, 6'd20);
        watch(fc, dc, rc, sc, fn, fp, fl);
        tests++; if (fc != 19 || valid_dbg !== 16'h0001) begin fails++; $display("FAIL abort_fresh: cycle=%0d table=%h want 19/0001", fc, valid_dbg); end
    endtask

    initial begin
        test_reset();
        test_interest();
        test_aggregate();
        test_data_grant();
        test_pending();
        test_table_full();
        test_reuse();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
